// File: rtl/vector_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vector_sequencer
//  Description : On-chip stimulus/check controller. Steps through a
//                synchronous vector memory, drives each stimulus onto the
//                datapath, waits a settle interval, compares the datapath
//                response against the expected fields and tallies mismatches.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_sequencer #(
    parameter  int WIDTH   = 8,
    parameter  int NUM_VEC = 10,
    parameter  int ADDR_W  = 4,
    parameter  int SETTLE  = 1,
    localparam int VEC_W   = 2*WIDTH+9
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active low
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] vec_addr,
    output logic              vec_rd,
    input  logic [VEC_W-1:0]  vec_data,
    output logic [WIDTH-1:0]  data_in,
    output logic              a,
    output logic              b,
    output logic [4:0]        x,
    input  logic [WIDTH-1:0]  data_out,
    input  logic              out,
    input  logic              d,
    output logic              busy,
    output logic              chk_valid,
    output logic              chk_fail,
    output logic [ADDR_W-1:0] vecnum,
    output logic [15:0]       errors,
    output logic              done,
    output logic              pass
);

    // State encoding
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_LOAD   = 3'd2;
    localparam logic [2:0] c_SETTLE = 3'd3;
    localparam logic [2:0] c_CHECK  = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;

    localparam logic [ADDR_W-1:0] c_LAST_VEC   = ADDR_W'(NUM_VEC-1);
    localparam logic [3:0]        c_SETTLE_CNT = 4'(SETTLE);
    localparam logic [15:0]       c_ERR_MAX    = 16'hFFFF;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_vecnum;
    logic [15:0]       r_errors;
    logic              r_pass;
    logic [3:0]        r_settle_cnt;

    // Stimulus currently applied and the response expected for it
    logic [WIDTH-1:0]  r_data_in;
    logic              r_a;
    logic              r_b;
    logic [4:0]        r_x;
    logic [WIDTH-1:0]  r_exp_data;
    logic              r_exp_out;
    logic              r_exp_d;

    // Vector word fields, MSB to LSB: {data_in, a, b, x, data_out, out, d}
    logic [WIDTH-1:0]  w_vec_data_in;
    logic              w_vec_a;
    logic              w_vec_b;
    logic [4:0]        w_vec_x;
    logic [WIDTH-1:0]  w_vec_exp_data;
    logic              w_vec_exp_out;
    logic              w_vec_exp_d;

    assign w_vec_data_in  = vec_data[VEC_W-1 -: WIDTH];
    assign w_vec_a        = vec_data[WIDTH+8];
    assign w_vec_b        = vec_data[WIDTH+7];
    assign w_vec_x        = vec_data[WIDTH+6 -: 5];
    assign w_vec_exp_data = vec_data[WIDTH+1 -: WIDTH];
    assign w_vec_exp_out  = vec_data[1];
    assign w_vec_exp_d    = vec_data[0];

    // A compare is live only in CHECK and only if the run is not being aborted
    logic        w_check;
    logic        w_mismatch;
    logic [15:0] w_errors_inc;

    assign w_check      = (r_state == c_CHECK) && !abort;
    assign w_mismatch   = (data_out != r_exp_data) || (out != r_exp_out) || (d != r_exp_d);
    assign w_errors_inc = (r_errors == c_ERR_MAX) ? r_errors : r_errors + 16'd1;

    // Sequencer: run control, vector index, settle timing, stimulus and error tally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_IDLE;
            r_vecnum     <= '0;
            r_errors     <= '0;
            r_pass       <= 1'b0;
            r_settle_cnt <= '0;
            r_data_in    <= '0;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_x          <= '0;
            r_exp_data   <= '0;
            r_exp_out    <= 1'b0;
            r_exp_d      <= 1'b0;
        end else if (abort) begin
            // Abort drops back to IDLE; counters and stimulus are left as-is
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_vecnum <= '0;
                        r_errors <= '0;
                        r_pass   <= 1'b0;
                        r_state  <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    r_state <= c_LOAD;
                end
                c_LOAD: begin
                    r_data_in    <= w_vec_data_in;
                    r_a          <= w_vec_a;
                    r_b          <= w_vec_b;
                    r_x          <= w_vec_x;
                    r_exp_data   <= w_vec_exp_data;
                    r_exp_out    <= w_vec_exp_out;
                    r_exp_d      <= w_vec_exp_d;
                    r_settle_cnt <= c_SETTLE_CNT;
                    r_state      <= c_SETTLE;
                end
                c_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt - 4'd1;
                    if (r_settle_cnt <= 4'd1) begin
                        r_state <= c_CHECK;
                    end
                end
                c_CHECK: begin
                    if (w_mismatch) begin
                        r_errors <= w_errors_inc;
                    end
                    if (r_vecnum == c_LAST_VEC) begin
                        r_state <= c_DONE;
                    end else begin
                        r_vecnum <= r_vecnum + ADDR_W'(1);
                        r_state  <= c_FETCH;
                    end
                end
                c_DONE: begin
                    r_pass  <= (r_errors == 16'd0);
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != c_IDLE);
    assign vec_rd    = (r_state == c_FETCH);
    assign vec_addr  = vec_rd ? r_vecnum : '0;
    assign chk_valid = w_check;
    assign chk_fail  = w_check && w_mismatch;
    assign done      = (r_state == c_DONE) && !abort;
    assign vecnum    = r_vecnum;
    assign errors    = r_errors;
    assign pass      = r_pass;
    assign data_in   = r_data_in;
    assign a         = r_a;
    assign b         = r_b;
    assign x         = r_x;

endmodule
`default_nettype wire

// File: tb/tb_vector_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_sequencer
//  Description : Directed self-checking bench for vector_sequencer. One
//                instance runs 10 vectors with SETTLE=1 against a
//                combinational datapath model; a second runs 2 vectors with
//                SETTLE=3 against a 2-cycle-latency datapath model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    // Reference datapath: data_out = ~data_in, out = a|b, d = ^x ^ a
    function automatic logic [9:0] dp(input logic [7:0] di, input logic ai,
                                      input logic bi, input logic [4:0] xi);
        return {~di, ai | bi, (^xi) ^ ai};
    endfunction

    function automatic logic [24:0] mkvec(input logic [7:0] di, input logic ai,
                                          input logic bi, input logic [4:0] xi);
        return {di, ai, bi, xi, dp(di, ai, bi, xi)};
    endfunction

    // ---------------- main instance: NUM_VEC=10, SETTLE=1 ----------------
    logic        start = 1'b0, abort = 1'b0;
    logic [3:0]  vec_addr;
    logic        vec_rd;
    logic [24:0] vec_data = '0;
    logic [7:0]  data_in, data_out;
    logic        a, b, out_s, d_s;
    logic [4:0]  x;
    logic        busy, chk_valid, chk_fail, done, pass;
    logic [3:0]  vecnum;
    logic [15:0] errors;
    logic        fault_a5 = 1'b0, fault_all = 1'b0;
    logic [24:0] mem [16];

    vector_sequencer #(.WIDTH(8), .NUM_VEC(10), .ADDR_W(4), .SETTLE(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vec_addr(vec_addr), .vec_rd(vec_rd), .vec_data(vec_data),
        .data_in(data_in), .a(a), .b(b), .x(x),
        .data_out(data_out), .out(out_s), .d(d_s),
        .busy(busy), .chk_valid(chk_valid), .chk_fail(chk_fail),
        .vecnum(vecnum), .errors(errors), .done(done), .pass(pass)
    );

    always @(posedge clk) if (vec_rd) vec_data <= mem[vec_addr];

    assign {data_out, out_s, d_s} = dp(data_in, a, b, x)
        ^ {7'b0, (fault_all | (fault_a5 & (data_in == 8'hA5))), 2'b0};

    int mon_chk = 0, mon_fail = 0, mon_done = 0, mon_gap_bad = 0, last_chk = 0;
    logic [3:0] mon_fail_vec = '0;
    always @(negedge clk) begin
        if (chk_valid) begin
            mon_chk <= mon_chk + 1;
            if (chk_fail) begin
                mon_fail     <= mon_fail + 1;
                mon_fail_vec <= vecnum;
            end
            if (vecnum != 4'd0 && (cyc - last_chk) != 4) mon_gap_bad <= mon_gap_bad + 1;
            last_chk <= cyc;
        end
        if (done) mon_done <= mon_done + 1;
    end

    // ---------------- second instance: NUM_VEC=2, SETTLE=3 ----------------
    logic        start3 = 1'b0, abort3 = 1'b0;
    logic [3:0]  vec_addr3;
    logic        vec_rd3;
    logic [24:0] vec_data3 = '0;
    logic [7:0]  data_in3, data_out3;
    logic        a3, b3, out3, d3;
    logic [4:0]  x3;
    logic        busy3, chk_valid3, chk_fail3, done3, pass3;
    logic [3:0]  vecnum3;
    logic [15:0] errors3;
    logic [24:0] mem3 [16];
    logic [9:0]  pipe1 = '0, pipe2 = '0;

    vector_sequencer #(.WIDTH(8), .NUM_VEC(2), .ADDR_W(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3),
        .vec_addr(vec_addr3), .vec_rd(vec_rd3), .vec_data(vec_data3),
        .data_in(data_in3), .a(a3), .b(b3), .x(x3),
        .data_out(data_out3), .out(out3), .d(d3),
        .busy(busy3), .chk_valid(chk_valid3), .chk_fail(chk_fail3),
        .vecnum(vecnum3), .errors(errors3), .done(done3), .pass(pass3)
    );

    always @(posedge clk) if (vec_rd3) vec_data3 <= mem3[vec_addr3];

    // Datapath with two cycles of output latency
    always @(posedge clk) begin
        pipe1 <= dp(data_in3, a3, b3, x3);
        pipe2 <= pipe1;
    end
    assign {data_out3, out3, d3} = pipe2;

    int mon3_chk = 0, mon3_fail = 0, mon3_gap_bad = 0, last_chk3 = 0;
    always @(negedge clk) begin
        if (chk_valid3) begin
            mon3_chk <= mon3_chk + 1;
            if (chk_fail3) mon3_fail <= mon3_fail + 1;
            if (vecnum3 != 4'd0 && (cyc - last_chk3) != 6) mon3_gap_bad <= mon3_gap_bad + 1;
            last_chk3 <= cyc;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int max_cyc, output int dcyc);
        dcyc = -1000;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    int s, dcyc, base_chk, base_fail, base_done, base_gap;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]  = mkvec(8'(i*37+5), i[0], i[1], 5'(i*3+1));
            mem3[i] = '0;
        end
        mem[3]  = mkvec(8'hA5, 1'b1, 1'b0, 5'd7);
        mem3[0] = mkvec(8'h3C, 1'b0, 1'b1, 5'd9);
        mem3[1] = mkvec(8'hC3, 1'b1, 1'b1, 5'd22);

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_stim", {data_in, a, b, x}, 15'd0);
        check("rst_ctrl", {busy, vec_rd, vec_addr, chk_valid, chk_fail, done, pass}, 10'd0);
        check("rst_cnt", {errors, vecnum}, 20'd0);
        check("vec3_layout", mem[3], {8'hA5, 1'b1, 1'b0, 5'd7, 8'h5A, 1'b1, 1'b0});
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // ---- all-pass run ----
        base_chk = mon_chk; base_fail = mon_fail; base_gap = mon_gap_bad;
        pulse_start(s);
        check("fetch0", {busy, vec_rd, vec_addr}, {1'b1, 1'b1, 4'd0});
        wait_done(100, dcyc);
        check("pass_run_len", dcyc - s + 1, 42);
        #1;
        check("pass_run_chks", mon_chk - base_chk, 10);
        check("pass_run_fails", mon_fail - base_fail, 0);
        check("pass_run_gaps", mon_gap_bad - base_gap, 0);
        @(negedge clk);
        check("pass_run_end", {busy, pass, errors}, {1'b0, 1'b1, 16'd0});
        check("stim_held", {data_in, a, b, x}, mem[9][24:10]);

        // ---- single mismatch on vector 3 ----
        fault_a5 = 1'b1;
        base_fail = mon_fail;
        pulse_start(s);
        wait_done(100, dcyc);
        #1;
        check("mis_fails", mon_fail - base_fail, 1);
        check("mis_vec", mon_fail_vec, 4'd3);
        @(negedge clk);
        check("mis_end", {pass, errors}, {1'b0, 16'd1});

        // ---- abort while vector 5 settles ----
        base_done = mon_done;
        pulse_start(s);
        repeat (22) @(negedge clk);
        check("abort_pre", {vecnum, busy, vec_rd}, {4'd5, 1'b1, 1'b0});
        abort = 1'b1;
        @(negedge clk);
        check("abort_idle", {busy, done, chk_valid, pass}, 4'b0000);
        check("abort_held", {vecnum, errors}, {4'd5, 16'd1});
        check("abort_stim", {data_in, a, b, x}, mem[5][24:10]);
        start = 1'b1;                       // start together with abort
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_wins", {busy, vecnum}, {1'b0, 4'd5});
        @(negedge clk);
        #1;
        check("abort_no_done", mon_done - base_done, 0);
        fault_a5 = 1'b0;
        @(negedge clk);
        pulse_start(s);
        check("restart", {busy, vecnum, errors, vec_addr}, {1'b1, 4'd0, 16'd0, 4'd0});
        wait_done(100, dcyc);
        @(negedge clk);
        check("restart_end", {pass, errors}, {1'b1, 16'd0});

        // ---- SETTLE=3, 2-cycle-latency datapath ----
        base_chk = mon3_chk; base_fail = mon3_fail; base_gap = mon3_gap_bad;
        start3 = 1'b1;
        s = cyc;
        @(negedge clk);
        start3 = 1'b0;
        @(negedge clk);                     // LOAD cycle: stimulus not yet updated
        check("s3_load_old", data_in3, 8'h00);
        @(negedge clk);
        check("s3_load_new", {data_in3, a3, b3, x3}, mem3[0][24:10]);
        dcyc = -1000;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done3) begin
                dcyc = cyc;
                break;
            end
        end
        check("s3_run_len", dcyc - s + 1, 14);
        #1;
        check("s3_chks", mon3_chk - base_chk, 2);
        check("s3_fails", mon3_fail - base_fail, 0);
        check("s3_gaps", mon3_gap_bad - base_gap, 0);
        @(negedge clk);
        check("s3_pass", {pass3, errors3}, {1'b1, 16'd0});

        // ---- error counter saturation ----
        fault_all = 1'b1;
        base_fail = mon_fail;
        pulse_start(s);
        force u_dut.r_errors = 16'hFFFE;
        @(negedge clk);
        release u_dut.r_errors;
        check("sat_preload", errors, 16'hFFFE);
        repeat (3) @(negedge clk);
        check("sat_1", errors, 16'hFFFF);
        repeat (4) @(negedge clk);
        check("sat_2", errors, 16'hFFFF);
        @(negedge clk);
        start = 1'b1;                       // ignored while busy
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("sat_3", errors, 16'hFFFF);
        check("start_ignored", {busy, vecnum}, {1'b1, 4'd3});
        wait_done(100, dcyc);
        check("sat_run_len", dcyc - s + 1, 42);
        #1;
        check("sat_fails", mon_fail - base_fail, 10);
        @(negedge clk);
        check("sat_end", {pass, errors}, {1'b0, 16'hFFFF});
        fault_all = 1'b0;

        // ---- reset mid-run ----
        pulse_start(s);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid", {busy, done, vecnum, errors, data_in, pass}, 31'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
Hardware stimulus/check controller for the `file` datapath: `data_in`/`a`/`b`/`x` in, `data_out`/`out`/`d` out. It steps through a synchronous vector memory, applies each stimulus, waits a settle interval, then compares the datapath outputs against the expected fields. It counts mismatches and reports pass/done. It replaces the software vector loop so regression runs on-chip and on FPGA.

Parameters:
WIDTH, 8, width of `data_in`/`data_out`; must match the datapath `WIDTH`.
NUM_VEC, 10, number of vectors per run (1..2^ADDR_W).
ADDR_W, 4, vector memory address width.
SETTLE, 1, idle cycles between stimulus update and compare (1..15).
VEC_W, 2*WIDTH+9, vector word width (derived, not overridable).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-low reset.
start  in  1  1-cycle pulse; begins a run from vector 0; ignored while busy.
abort  in  1  level; forces IDLE from any state.
vec_addr  out  ADDR_W  vector memory read address.
vec_rd  out  1  vector memory read enable.
vec_data  in  VEC_W  memory read data, valid 1 cycle after vec_rd.
data_in  out  WIDTH  stimulus to datapath.
a  out  1  stimulus.
b  out  1  stimulus.
x  out  5  stimulus.
data_out  in  WIDTH  datapath response.
out  in  1  datapath response.
d  in  1  datapath response.
busy  out  1  high in any state except IDLE.
chk_valid  out  1  1-cycle pulse on each compare.
chk_fail  out  1  qualifies chk_valid; 1 = mismatch.
vecnum  out  ADDR_W  index of the current vector.
errors  out  16  mismatch count, saturates at 16'hFFFF.
done  out  1  1-cycle pulse when the last vector has been checked.
pass  out  1  level; set at done if errors==0, cleared on start/reset.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs are 0, including stimulus, vec_addr, vecnum, errors and pass.
- Vector word layout, MSB to LSB: {data_in, a, b, x, data_out_exp, out_exp, d_exp}. For WIDTH=8 this is 25 bits: [24:17] data_in, [16] a, [15] b, [14:10] x, [9:2] data_out_exp, [1] out_exp, [0] d_exp.
- FSM states: IDLE, FETCH, LOAD, SETTLE, CHECK, DONE.
- IDLE: on start, clear vecnum, errors and pass, then go to FETCH.
- FETCH: vec_rd=1 and vec_addr=vecnum for exactly one cycle; go to LOAD.
- LOAD: vec_data is valid. At the closing edge, register the stimulus outputs and the internal expected fields, load the settle counter with SETTLE, and go to SETTLE.
- SETTLE: decrement the counter each cycle; stimulus is held stable. Go to CHECK when the counter reaches 1.
- CHECK: compare data_out/out/d against the expected fields (all three must match). Pulse chk_valid; chk_fail = mismatch. On mismatch, errors+1, saturating. If vecnum==NUM_VEC-1, go to DONE; otherwise vecnum+1 and go to FETCH.
- DONE: pulse done for 1 cycle, set pass = (errors==0), return to IDLE.
- Stimulus outputs hold their last values in IDLE after a run. They change only at the LOAD closing edge.
- Per-vector period is SETTLE+3 cycles, i.e. 4 cycles at the default.
- Run length: NUM_VEC*(SETTLE+3) + 2 cycles from the start edge to the done pulse, counting the IDLE→FETCH and DONE cycles.
- start while busy: ignored, with no effect on counters.
- start and abort asserted together: abort wins.
- abort in any state:
  - next state is IDLE.
  - done, chk_valid and pass are not asserted.
  - errors and vecnum retain their values.
  - stimulus is held.
- Reset mid-run: immediate return to the reset values above; no done pulse.
- errors at 16'hFFFF stays 16'hFFFF on further mismatches.
- vecnum never exceeds NUM_VEC-1. With NUM_VEC=1, the first CHECK goes straight to DONE.

Test Plan:
1. Reset then idle: rst low, then high → all outputs 0, busy=0. start pulse → busy=1 next cycle, vec_rd=1 with vec_addr=0.
2. All-pass run, NUM_VEC=10, SETTLE=1, datapath model matching every vector → 10 chk_valid pulses with chk_fail=0, 4 cycles apart. done at cycle 42 after start; pass=1, errors=0.
3. Mismatch: vector 3 = {8'hA5,1,0,5'd7,8'h5A,1,0}, datapath returns data_out=8'h5B → chk_fail=1 on vecnum=3 only. Final errors=1, pass=0.
4. Abort while vecnum=5 in SETTLE → IDLE next cycle, busy=0, no done pulse, errors and vecnum=5 held. A following start restarts from vecnum=0 with errors=0.
5. SETTLE=3: stimulus changes at the LOAD edge; the compare happens 3 cycles later, per-vector period 6. A datapath with 2-cycle output latency passes.
6. Saturation: force errors=16'hFFFE, apply 3 mismatching vectors → errors reads FFFF, FFFF, FFFF. start pulsed mid-run is ignored.
